// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter that shares one bitwise logic unit (AND/OR/XOR/NOR) between two requesters.
// The unit grants one requester, holds for LAT execution cycles, then returns a registered result with a done pulse.
module logic_unit_arbiter #(
    parameter int unsigned W   = 8,
    parameter int unsigned LAT = 1
) (
    input  logic         CLK,
    input  logic         RST_N,
    input  logic         REQ0,
    input  logic [1:0]   OP0,
    input  logic [W-1:0] A0,
    input  logic [W-1:0] B0,
    input  logic         REQ1,
    input  logic [1:0]   OP1,
    input  logic [W-1:0] A1,
    input  logic [W-1:0] B1,
    output logic         GNT0,
    output logic         GNT1,
    output logic         DONE0,
    output logic         DONE1,
    output logic [W-1:0] Z,
    output logic         BUSY
);

    localparam int unsigned CW = (LAT > 1) ? $clog2(LAT) : 1;
    localparam logic [CW-1:0] LAT_M1 = CW'(LAT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e        state_q;
    logic          prio_q;
    logic          port_q;
    logic [CW-1:0] cnt_q;
    logic [1:0]    op_q;
    logic [W-1:0]  a_q;
    logic [W-1:0]  b_q;
    logic          gnt0_q;
    logic          gnt1_q;
    logic          done0_q;
    logic          done1_q;
    logic [W-1:0]  z_q;

    logic          win_c;
    logic [W-1:0]  result_c;

    // A lone requester wins outright; a tie goes to the priority port.
    always_comb begin
        win_c = REQ1;
        if (REQ0 && REQ1) begin
            win_c = prio_q;
        end
    end

    // Shared logic unit, operating on the latched operands.
    always_comb begin
        result_c = '0;
        case (op_q)
            2'b00:   result_c = a_q & b_q;
            2'b01:   result_c = a_q | b_q;
            2'b10:   result_c = a_q ^ b_q;
            default: result_c = ~(a_q | b_q);
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            prio_q  <= 1'b0;
            port_q  <= 1'b0;
            cnt_q   <= '0;
            op_q    <= 2'b00;
            a_q     <= '0;
            b_q     <= '0;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            z_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (REQ0 || REQ1) begin
                        port_q  <= win_c;
                        op_q    <= win_c ? OP1 : OP0;
                        a_q     <= win_c ? A1 : A0;
                        b_q     <= win_c ? B1 : B0;
                        gnt0_q  <= ~win_c;
                        gnt1_q  <= win_c;
                        cnt_q   <= LAT_M1;
                        state_q <= EXEC;
                    end
                end
                EXEC: begin
                    gnt0_q <= 1'b0;
                    gnt1_q <= 1'b0;
                    if (cnt_q == '0) begin
                        z_q     <= result_c;
                        done0_q <= ~port_q;
                        done1_q <= port_q;
                        state_q <= RESP;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                RESP: begin
                    done0_q <= 1'b0;
                    done1_q <= 1'b0;
                    prio_q  <= ~port_q;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign GNT0  = gnt0_q;
    assign GNT1  = gnt1_q;
    assign DONE0 = done0_q;
    assign DONE1 = done1_q;
    assign Z     = z_q;
    assign BUSY  = (state_q != IDLE);

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Bench for logic_unit_arbiter: three instances (LAT=1,2,3) share one stimulus stream and are
// compared every cycle against a transaction-timeline reference model.
module tb_logic_unit_arbiter;

    localparam int unsigned W  = 8;
    localparam int          NI = 3;

    logic         CLK;
    logic         RST_N;
    logic         req0, req1;
    logic [1:0]   op0, op1;
    logic [W-1:0] a0, b0, a1, b1;

    logic [NI-1:0] gnt0_o, gnt1_o, done0_o, done1_o, busy_o;
    logic [W-1:0]  z_o [NI];

    int errors = 0;
    int checks = 0;

    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
        logic_unit_arbiter #(.W(W), .LAT(gi + 1)) u_dut (
            .CLK   (CLK),
            .RST_N (RST_N),
            .REQ0  (req0),
            .OP0   (op0),
            .A0    (a0),
            .B0    (b0),
            .REQ1  (req1),
            .OP1   (op1),
            .A1    (a1),
            .B1    (b1),
            .GNT0  (gnt0_o[gi]),
            .GNT1  (gnt1_o[gi]),
            .DONE0 (done0_o[gi]),
            .DONE1 (done1_o[gi]),
            .Z     (z_o[gi]),
            .BUSY  (busy_o[gi])
        );
    end

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference model: each instance is either free or holding a transaction whose
    // done edge and release edge are fixed at grant time (grant+LAT, grant+LAT+1).
    int           edge_n;
    bit           m_busy  [NI];
    int           m_done_e[NI];
    int           m_free_e[NI];
    bit           m_srv   [NI];
    bit           m_prio  [NI];
    logic [1:0]   m_op    [NI];
    logic [W-1:0] m_a     [NI];
    logic [W-1:0] m_b     [NI];
    logic [W-1:0] m_z     [NI];
    bit           m_g0[NI], m_g1[NI], m_d0[NI], m_d1[NI];

    function automatic logic [W-1:0] ref_op(input logic [1:0] op, input logic [W-1:0] a,
                                            input logic [W-1:0] b);
        case (op)
            2'b00:   return a & b;
            2'b01:   return a | b;
            2'b10:   return a ^ b;
            default: return ~(a | b);
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NI; i++) begin
            m_busy[i] = 0; m_prio[i] = 0; m_srv[i] = 0;
            m_done_e[i] = -1; m_free_e[i] = -1;
            m_z[i] = '0;
            m_g0[i] = 0; m_g1[i] = 0; m_d0[i] = 0; m_d1[i] = 0;
        end
    endtask

    task automatic model_edge();
        bit w;
        edge_n++;
        for (int i = 0; i < NI; i++) begin
            m_g0[i] = 0; m_g1[i] = 0; m_d0[i] = 0; m_d1[i] = 0;
            if (!m_busy[i]) begin
                if (req0 || req1) begin
                    w = (req0 && req1) ? m_prio[i] : req1;
                    m_srv[i] = w;
                    m_op[i]  = w ? op1 : op0;
                    m_a[i]   = w ? a1 : a0;
                    m_b[i]   = w ? b1 : b0;
                    if (w) m_g1[i] = 1; else m_g0[i] = 1;
                    m_busy[i]   = 1;
                    m_done_e[i] = edge_n + i + 1;
                    m_free_e[i] = edge_n + i + 2;
                end
            end else if (edge_n == m_done_e[i]) begin
                m_z[i] = ref_op(m_op[i], m_a[i], m_b[i]);
                if (m_srv[i]) m_d1[i] = 1; else m_d0[i] = 1;
            end else if (edge_n == m_free_e[i]) begin
                m_prio[i] = !m_srv[i];
                m_busy[i] = 0;
            end
        end
    endtask

    task automatic chk(input string tag, input int idx, input logic [W-1:0] obs,
                       input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s[lat=%0d] edge=%0d observed=%h expected=%h", tag, idx + 1, edge_n, obs, exp);
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < NI; i++) begin
            chk("gnt0",  i, W'(gnt0_o[i]),  W'(m_g0[i]));
            chk("gnt1",  i, W'(gnt1_o[i]),  W'(m_g1[i]));
            chk("done0", i, W'(done0_o[i]), W'(m_d0[i]));
            chk("done1", i, W'(done1_o[i]), W'(m_d1[i]));
            chk("busy",  i, W'(busy_o[i]),  W'(m_busy[i]));
            chk("z",     i, z_o[i],         m_z[i]);
        end
    endtask

    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge CLK);
            model_edge();
            #1;
            check_all();
        end
    endtask

    // Asynchronous reset applied between edges; outputs must clear before any edge.
    task automatic async_reset();
        RST_N = 1'b0;
        #2;
        model_reset();
        check_all();
        #2;
        RST_N = 1'b1;
    endtask

    initial begin
        RST_N = 1'b0;
        req0 = 0; req1 = 0; op0 = 0; op1 = 0; a0 = 0; b0 = 0; a1 = 0; b1 = 0;
        edge_n = 0;
        model_reset();
        #12;
        check_all();
        RST_N = 1'b1;

        // Single OR on port 0.
        req0 = 1; op0 = 2'b01; a0 = 8'hF0; b0 = 8'h0C;
        step(1);
        req0 = 0;
        step(5);
        chk("or_result", 0, z_o[0], 8'hFC);

        // Simultaneous requests after reset: port 0 first, then port 1.
        async_reset();
        req0 = 1; op0 = 2'b00; a0 = 8'hF0; b0 = 8'h0C;
        req1 = 1; op1 = 2'b10; a1 = 8'hAA; b1 = 8'h0F;
        step(2);
        chk("and_result", 0, z_o[0], 8'h00);
        step(3);
        chk("xor_result", 0, z_o[0], 8'hA5);

        // Both held for a long stretch: grants must alternate.
        step(20);
        req0 = 0; req1 = 0;
        step(6);

        // Port 0 drops REQ and changes A after the grant; latched operands must be used.
        req0 = 1; op0 = 2'b00; a0 = 8'h33; b0 = 8'h0F;
        step(1);
        req0 = 0; a0 = 8'hFF;
        step(5);
        chk("latched_and", 1, z_o[1], 8'h03);

        // NOR on port 1; the LAT=3 instance completes three edges after grant.
        req1 = 1; op1 = 2'b11; a1 = 8'hF0; b1 = 8'h0C;
        step(1);
        req1 = 0;
        step(3);
        chk("nor_done1", 2, W'(done1_o[2]), 8'h01);
        chk("nor_result", 2, z_o[2], 8'h03);
        step(2);

        // Reset in the middle of execution discards the transaction.
        req0 = 1; op0 = 2'b10; a0 = 8'h5A; b0 = 8'hFF;
        step(2);
        req0 = 0;
        async_reset();
        step(6);
        req1 = 1; op1 = 2'b01; a1 = 8'h12; b1 = 8'h40;
        step(1);
        req1 = 0;
        step(5);

        // Random traffic, with an occasional asynchronous reset.
        for (int n = 0; n < 400; n++) begin
            req0 = ($urandom_range(0, 9) < 6);
            req1 = ($urandom_range(0, 9) < 6);
            op0  = 2'($urandom_range(0, 3));
            op1  = 2'($urandom_range(0, 3));
            a0   = W'($urandom); b0 = W'($urandom);
            a1   = W'($urandom); b1 = W'($urandom);
            if ($urandom_range(0, 99) == 0) async_reset();
            step(1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
